// File: rtl/fast_corner_detect_if.sv
// ============================================================================
// Module   : fast_corner_detect_if
// Brief    : Control, image-read and score-write bus of the FAST corner stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface fast_corner_detect_if #(
  parameter int X_MAX       = 200,
  parameter int Y_MAX       = 200,
  parameter int PIXEL_DEPTH = 8
);
  logic                       new_trans;
  logic                       fast_done;
  logic [$clog2(X_MAX)-1:0]   max_x;
  logic [$clog2(Y_MAX)-1:0]   max_y;
  logic [PIXEL_DEPTH-1:0]     threshold;
  logic [$clog2(X_MAX):0]     x_addr_img;
  logic [$clog2(Y_MAX):0]     y_addr_img;
  logic                       ren_img;
  logic [PIXEL_DEPTH-1:0]     rdat_img;
  logic [$clog2(X_MAX):0]     x_addr_corner;
  logic [$clog2(Y_MAX):0]     y_addr_corner;
  logic                       wen_corner;
  logic [PIXEL_DEPTH-1:0]     wdat_corner;

  modport master (
    output new_trans, max_x, max_y, threshold, rdat_img,
    input  fast_done, x_addr_img, y_addr_img, ren_img,
           x_addr_corner, y_addr_corner, wen_corner, wdat_corner
  );

  modport slave (
    input  new_trans, max_x, max_y, threshold, rdat_img,
    output fast_done, x_addr_img, y_addr_img, ren_img,
           x_addr_corner, y_addr_corner, wen_corner, wdat_corner
  );
endinterface

`default_nettype wire

// File: rtl/fast_corner_detect.sv
// ============================================================================
// Module   : fast_corner_detect
// Brief    : FAST-16 segment test over the blurred image; one score per pixel.
//            Optional FAST_EARLY_REJECT_EN adds a compass-pixel pre-check.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fast_corner_detect #(
  parameter int X_MAX       = 200,
  parameter int Y_MAX       = 200,
  parameter int PIXEL_DEPTH = 8,
  parameter int ARC_LEN     = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  fast_corner_detect_if.slave  bus
);

  localparam int XW = $clog2(X_MAX);
  localparam int YW = $clog2(Y_MAX);
  localparam int XA = XW + 1;
  localparam int YA = YW + 1;
  localparam int PD = PIXEL_DEPTH;
  localparam int SW = PD + 4;
  localparam int CW = 5;
  localparam logic [PD-1:0] PIX_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_CAPTURE = 3'd2,
    S_CHECK   = 3'd3,
    S_EVAL    = 3'd4,
    S_WRITE   = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [XW-1:0]     r_max_x;
  logic [YW-1:0]     r_max_y;
  logic [PD-1:0]     r_thr;
  logic [XA-1:0]     r_cand_x;
  logic [YA-1:0]     r_cand_y;
  logic [PD-1:0]     r_center;
  logic [PD-1:0]     r_ring [16];
  logic              r_rd_pend;
  logic [4:0]        r_rd_slot;
  logic [CW-1:0]     r_brun, r_drun, r_bmax, r_dmax;
  logic [SW-1:0]     r_bsum, r_dsum;
`ifdef FAST_EARLY_REJECT_EN
  logic              r_phase;
  logic              r_reject;
  logic              w_reject;
`endif

  // bit1 = bright, bit0 = dark; sums kept one bit wider so c+t cannot wrap
  function automatic logic [1:0] classify(input logic [PD-1:0] p,
                                          input logic [PD-1:0] c,
                                          input logic [PD-1:0] t);
    logic [PD:0] hi;
    logic [PD:0] lo;
    logic [1:0]  res;
    hi     = {1'b0, c} + {1'b0, t};
    lo     = {1'b0, c} - {1'b0, t};
    res[1] = ({1'b0, p} > hi);
    res[0] = (c >= t) && ({1'b0, p} < lo);
    return res;
  endfunction

  function automatic logic [2:0] ring_dx(input logic [3:0] idx);
    logic [2:0] d;
    case (idx)
      4'd0, 4'd8:              d = 3'b000;
      4'd1, 4'd7:              d = 3'b001;
      4'd2, 4'd6:              d = 3'b010;
      4'd3, 4'd4, 4'd5:        d = 3'b011;
      4'd9, 4'd15:             d = 3'b111;
      4'd10, 4'd14:            d = 3'b110;
      default:                 d = 3'b101;
    endcase
    return d;
  endfunction

  function automatic logic [2:0] ring_dy(input logic [3:0] idx);
    logic [2:0] d;
    case (idx)
      4'd4, 4'd12:             d = 3'b000;
      4'd5, 4'd11:             d = 3'b001;
      4'd6, 4'd10:             d = 3'b010;
      4'd7, 4'd8, 4'd9:        d = 3'b011;
      4'd3, 4'd13:             d = 3'b111;
      4'd2, 4'd14:             d = 3'b110;
      default:                 d = 3'b101;
    endcase
    return d;
  endfunction

  // Fetch sequencing: slot 0 is the centre, slot k is ring[k-1]
  logic [4:0] w_slot;
  logic       w_fetch_last;

  always_comb begin
    w_slot       = r_cnt;
    w_fetch_last = (r_cnt == 5'd16);
`ifdef FAST_EARLY_REJECT_EN
    if (!r_phase) begin
      w_fetch_last = (r_cnt == 5'd4);
      case (r_cnt)
        5'd0:    w_slot = 5'd0;
        5'd1:    w_slot = 5'd1;
        5'd2:    w_slot = 5'd5;
        5'd3:    w_slot = 5'd9;
        default: w_slot = 5'd13;
      endcase
    end else begin
      w_fetch_last = (r_cnt == 5'd11);
      case (r_cnt)
        5'd0:    w_slot = 5'd2;
        5'd1:    w_slot = 5'd3;
        5'd2:    w_slot = 5'd4;
        5'd3:    w_slot = 5'd6;
        5'd4:    w_slot = 5'd7;
        5'd5:    w_slot = 5'd8;
        5'd6:    w_slot = 5'd10;
        5'd7:    w_slot = 5'd11;
        5'd8:    w_slot = 5'd12;
        5'd9:    w_slot = 5'd14;
        5'd10:   w_slot = 5'd15;
        default: w_slot = 5'd16;
      endcase
    end
`endif
  end

  logic [3:0]    w_ridx;
  logic [2:0]    w_dx, w_dy;
  logic [XA-1:0] w_x_rd;
  logic [YA-1:0] w_y_rd;

  assign w_ridx = 4'(w_slot - 5'd1);
  assign w_dx   = ring_dx(w_ridx);
  assign w_dy   = ring_dy(w_ridx);
  assign w_x_rd = (w_slot == 5'd0) ? r_cand_x : r_cand_x + {{(XA-3){w_dx[2]}}, w_dx};
  assign w_y_rd = (w_slot == 5'd0) ? r_cand_y : r_cand_y + {{(YA-3){w_dy[2]}}, w_dy};

  // Segment-test datapath for the ring pixel visited at EVAL step r_cnt
  logic [PD-1:0] w_p;
  logic [1:0]    w_cls;
  logic [CW-1:0] w_bnext, w_dnext;
  logic [SW-1:0] w_bdiff, w_ddiff;

  assign w_p     = r_ring[r_cnt[3:0]];
  assign w_cls   = classify(w_p, r_center, r_thr);
  assign w_bnext = w_cls[1] ? r_brun + 5'd1 : 5'd0;
  assign w_dnext = w_cls[0] ? r_drun + 5'd1 : 5'd0;
  assign w_bdiff = SW'(w_p) - SW'(r_center) - SW'(r_thr);
  assign w_ddiff = SW'(r_center) - SW'(r_thr) - SW'(w_p);

`ifdef FAST_EARLY_REJECT_EN
  // An arc of ARC_LEN contiguous pixels always covers ARC_LEN/4 compass pixels
  logic [1:0] w_c0, w_c4, w_c8, w_c12;
  logic [2:0] w_nb, w_nd;

  assign w_c0    = classify(r_ring[0],  r_center, r_thr);
  assign w_c4    = classify(r_ring[4],  r_center, r_thr);
  assign w_c8    = classify(r_ring[8],  r_center, r_thr);
  assign w_c12   = classify(r_ring[12], r_center, r_thr);
  assign w_nb    = 3'(w_c0[1]) + 3'(w_c4[1]) + 3'(w_c8[1]) + 3'(w_c12[1]);
  assign w_nd    = 3'(w_c0[0]) + 3'(w_c4[0]) + 3'(w_c8[0]) + 3'(w_c12[0]);
  assign w_reject = (w_nb < 3'(ARC_LEN / 4)) && (w_nd < 3'(ARC_LEN / 4));
`endif

  logic          w_corner_b, w_corner_d;
  logic [SW-1:0] w_sum;
  logic [PD-1:0] w_score;

  assign w_corner_b = (r_bmax >= CW'(ARC_LEN));
  assign w_corner_d = (r_dmax >= CW'(ARC_LEN));
  assign w_sum      = w_corner_b ? r_bsum : (w_corner_d ? r_dsum : '0);

  always_comb begin
    w_score = (w_sum > SW'(PIX_MAX)) ? PIX_MAX : w_sum[PD-1:0];
    if ((w_corner_b || w_corner_d) && (w_score == '0)) w_score = PD'(1);
`ifdef FAST_EARLY_REJECT_EN
    if (r_reject) w_score = '0;
`endif
  end

  logic w_last_x, w_last_y, w_small;

  assign w_last_x = (r_cand_x == XA'(r_max_x) - XA'(3));
  assign w_last_y = (r_cand_y == YA'(r_max_y) - YA'(3));
  assign w_small  = (bus.max_x < XW'(6)) || (bus.max_y < YW'(6));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (bus.new_trans) w_state_nxt = w_small ? S_DONE : S_FETCH;
`ifdef FAST_EARLY_REJECT_EN
      S_FETCH:   if (w_fetch_last) w_state_nxt = r_phase ? S_EVAL : S_CAPTURE;
      S_CAPTURE: w_state_nxt = S_CHECK;
      S_CHECK:   w_state_nxt = w_reject ? S_WRITE : S_FETCH;
`else
      S_FETCH:   if (w_fetch_last) w_state_nxt = S_CAPTURE;
      S_CAPTURE: w_state_nxt = S_EVAL;
`endif
      S_EVAL:    if (r_cnt == 5'd30) w_state_nxt = S_WRITE;
      S_WRITE:   w_state_nxt = (w_last_x && w_last_y) ? S_DONE : S_FETCH;
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_max_x   <= '0;
      r_max_y   <= '0;
      r_thr     <= '0;
      r_cand_x  <= '0;
      r_cand_y  <= '0;
      r_center  <= '0;
      for (int k = 0; k < 16; k++) r_ring[k] <= '0;
      r_rd_pend <= 1'b0;
      r_rd_slot <= '0;
      r_brun    <= '0;
      r_drun    <= '0;
      r_bmax    <= '0;
      r_dmax    <= '0;
      r_bsum    <= '0;
      r_dsum    <= '0;
`ifdef FAST_EARLY_REJECT_EN
      r_phase   <= 1'b0;
      r_reject  <= 1'b0;
`endif
    end else begin
      // Read data lands one cycle after its request, whatever state follows
      r_rd_pend <= (r_state == S_FETCH);
      r_rd_slot <= w_slot;
      if (r_rd_pend) begin
        if (r_rd_slot == 5'd0) r_center <= bus.rdat_img;
        else                   r_ring[4'(r_rd_slot - 5'd1)] <= bus.rdat_img;
      end

      case (r_state)
        S_IDLE: begin
          if (bus.new_trans) begin
            r_max_x  <= bus.max_x;
            r_max_y  <= bus.max_y;
            r_thr    <= bus.threshold;
            r_cand_x <= XA'(3);
            r_cand_y <= YA'(3);
            r_cnt    <= '0;
          end
        end
        S_FETCH: begin
          r_cnt  <= w_fetch_last ? 5'd0 : r_cnt + 5'd1;
          r_brun <= '0;
          r_drun <= '0;
          r_bmax <= '0;
          r_dmax <= '0;
          r_bsum <= '0;
          r_dsum <= '0;
        end
        S_CAPTURE: r_cnt <= '0;
`ifdef FAST_EARLY_REJECT_EN
        S_CHECK: begin
          r_reject <= w_reject;
          r_phase  <= 1'b1;
          r_cnt    <= '0;
        end
`endif
        S_EVAL: begin
          r_cnt  <= r_cnt + 5'd1;
          r_brun <= w_bnext;
          r_drun <= w_dnext;
          if (w_bnext > r_bmax) r_bmax <= w_bnext;
          if (w_dnext > r_dmax) r_dmax <= w_dnext;
          if (!r_cnt[4]) begin
            if (w_cls[1]) r_bsum <= r_bsum + w_bdiff;
            if (w_cls[0]) r_dsum <= r_dsum + w_ddiff;
          end
        end
        S_WRITE: begin
          r_cnt <= '0;
`ifdef FAST_EARLY_REJECT_EN
          r_phase  <= 1'b0;
          r_reject <= 1'b0;
`endif
          if (w_last_x) begin
            r_cand_x <= XA'(3);
            r_cand_y <= r_cand_y + YA'(1);
          end else begin
            r_cand_x <= r_cand_x + XA'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode straight from state so an async reset clears them at once
  assign bus.ren_img       = (r_state == S_FETCH);
  assign bus.x_addr_img    = (r_state == S_FETCH) ? w_x_rd : '0;
  assign bus.y_addr_img    = (r_state == S_FETCH) ? w_y_rd : '0;
  assign bus.wen_corner    = (r_state == S_WRITE);
  assign bus.x_addr_corner = (r_state == S_WRITE) ? r_cand_x : '0;
  assign bus.y_addr_corner = (r_state == S_WRITE) ? r_cand_y : '0;
  assign bus.wdat_corner   = (r_state == S_WRITE) ? w_score : '0;
  assign bus.fast_done     = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_fast_corner_detect.sv
// ============================================================================
// Module   : tb_fast_corner_detect
// Brief    : Directed self-checking bench for fast_corner_detect (ARC_LEN 9 and 10).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fast_corner_detect;

  localparam int XM = 200;
  localparam int YM = 200;
  localparam int PD = 8;
`ifdef FAST_EARLY_REJECT_EN
  localparam int FLAT_PERIOD = 8;
`else
  localparam int FLAT_PERIOD = 50;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       nt  = 1'b0;
  logic [7:0] mx  = 8'd0;
  logic [7:0] my  = 8'd0;
  logic [7:0] thr = 8'd0;
  logic [7:0] chk_mx = 8'd0;
  logic [7:0] chk_my = 8'd0;
  logic [7:0] rd, rd10;

  fast_corner_detect_if #(.X_MAX(XM), .Y_MAX(YM), .PIXEL_DEPTH(PD)) bus ();
  fast_corner_detect_if #(.X_MAX(XM), .Y_MAX(YM), .PIXEL_DEPTH(PD)) bus10 ();

  assign bus.new_trans   = nt;
  assign bus.max_x       = mx;
  assign bus.max_y       = my;
  assign bus.threshold   = thr;
  assign bus.rdat_img    = rd;
  assign bus10.new_trans = nt;
  assign bus10.max_x     = mx;
  assign bus10.max_y     = my;
  assign bus10.threshold = thr;
  assign bus10.rdat_img  = rd10;

  fast_corner_detect #(.X_MAX(XM), .Y_MAX(YM), .PIXEL_DEPTH(PD), .ARC_LEN(9))
    dut (.clk(clk), .rst(rst), .bus(bus.slave));
  fast_corner_detect #(.X_MAX(XM), .Y_MAX(YM), .PIXEL_DEPTH(PD), .ARC_LEN(10))
    dut10 (.clk(clk), .rst(rst), .bus(bus10.slave));

  logic [7:0] mem   [16][16];
  logic [7:0] map   [16][16];
  logic [7:0] map10 [16][16];

  int rdx [16] = '{0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
  int rdy [16] = '{-3, -3, -2, -1, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3};

  int checks = 0, errors = 0;
  int cyc = 0, frame = 0, nt_cyc = 0;
  int wr_count = 0, done_count = 0, ren_count = 0;
  int done_cyc = 0, last_wr = 0, first_wr = 0, first_ren = 0;
  int wr_frame = 0, ren_frame = 0, bad_rd = 0, bad_wr = 0;

  // Image SRAM model (1-cycle read) and write/done recorders
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.ren_img) begin
      ren_count <= ren_count + 1;
      if (ren_frame != frame) begin
        first_ren <= cyc;
        ren_frame <= frame;
      end
      if (bus.x_addr_img > {1'b0, chk_mx} || bus.y_addr_img > {1'b0, chk_my}) bad_rd <= bad_rd + 1;
      rd <= mem[bus.y_addr_img[3:0]][bus.x_addr_img[3:0]];
    end
    if (bus10.ren_img) rd10 <= mem[bus10.y_addr_img[3:0]][bus10.x_addr_img[3:0]];
    if (bus.wen_corner) begin
      map[bus.y_addr_corner[3:0]][bus.x_addr_corner[3:0]] <= bus.wdat_corner;
      wr_count <= wr_count + 1;
      last_wr  <= cyc;
      if (wr_frame != frame) begin
        first_wr <= cyc;
        wr_frame <= frame;
      end
      if (bus.x_addr_corner < 9'd3 || bus.x_addr_corner > {1'b0, chk_mx} - 9'd3 ||
          bus.y_addr_corner < 9'd3 || bus.y_addr_corner > {1'b0, chk_my} - 9'd3) bad_wr <= bad_wr + 1;
    end
    if (bus10.wen_corner)
      map10[bus10.y_addr_corner[3:0]][bus10.x_addr_corner[3:0]] <= bus10.wdat_corner;
    if (bus.fast_done) begin
      done_count <= done_count + 1;
      done_cyc   <= cyc;
    end
  end

  task automatic paint_fill(input logic [7:0] v);
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) mem[y][x] = v;
  endtask

  task automatic paint_ring(input int cx, input int cy, input int k, input logic [7:0] v);
    mem[cy + rdy[k]][cx + rdx[k]] = v;
  endtask

  task automatic start_frame(input logic [7:0] x, input logic [7:0] y, input logic [7:0] t);
    @(negedge clk);
    frame  = frame + 1;
    mx     = x;
    my     = y;
    thr    = t;
    chk_mx = x;
    chk_my = y;
    nt     = 1'b1;
    nt_cyc = cyc;
    @(negedge clk);
    nt     = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, output bit timed_out);
    int n = 0;
    while (done_count == d0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    timed_out = (done_count == d0);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (bus.ren_img !== 1'b0) begin errors++; $display("FAIL reset_ren: got %b want 0", bus.ren_img); end
    checks++; if (bus.wen_corner !== 1'b0) begin errors++; $display("FAIL reset_wen: got %b want 0", bus.wen_corner); end
    checks++; if (bus.fast_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.fast_done); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.wdat_corner !== 8'd0 || bus.ren_img !== 1'b0) begin
      errors++; $display("FAIL idle_outputs: wdat %0d ren %b want 0 0", bus.wdat_corner, bus.ren_img);
    end
  endtask

  task automatic test_flat;
    int d0, w0;
    bit to;
    paint_fill(8'd100);
    d0 = done_count; w0 = wr_count;
    start_frame(8'd15, 8'd15, 8'd10);
    wait_done(d0, 100 * FLAT_PERIOD + 100, to);
    checks++; if (to) begin errors++; $display("FAIL flat_done: fast_done missing, got timeout want pulse"); end
    checks++; if (wr_count - w0 !== 100) begin errors++; $display("FAIL flat_writes: got %0d want 100", wr_count - w0); end
    for (int y = 3; y <= 12; y++)
      for (int x = 3; x <= 12; x++) begin
        checks++;
        if (map[y][x] !== 8'd0) begin errors++; $display("FAIL flat_score(%0d,%0d): got %0d want 0", x, y, map[y][x]); end
      end
    checks++; if (first_ren !== nt_cyc + 1) begin errors++; $display("FAIL flat_first_ren: got %0d want %0d", first_ren, nt_cyc + 1); end
    checks++; if (first_wr !== nt_cyc + FLAT_PERIOD) begin errors++; $display("FAIL flat_first_wr: got %0d want %0d", first_wr, nt_cyc + FLAT_PERIOD); end
    checks++; if (last_wr - first_wr !== 99 * FLAT_PERIOD) begin errors++; $display("FAIL flat_span: got %0d want %0d", last_wr - first_wr, 99 * FLAT_PERIOD); end
    checks++; if (done_cyc !== last_wr + 1) begin errors++; $display("FAIL flat_done_cycle: got %0d want %0d", done_cyc, last_wr + 1); end
    checks++; if (bad_rd !== 0) begin errors++; $display("FAIL read_range: got %0d out-of-range reads want 0", bad_rd); end
    checks++; if (bad_wr !== 0) begin errors++; $display("FAIL write_range: got %0d out-of-range writes want 0", bad_wr); end
  endtask

  task automatic test_bright_corner;
    int d0;
    bit to;
    paint_fill(8'd50);
    for (int k = 0; k <= 8; k++) paint_ring(8, 8, k, 8'd80);
    d0 = done_count;
    start_frame(8'd15, 8'd15, 8'd10);
    wait_done(d0, 6000, to);
    checks++; if (to) begin errors++; $display("FAIL bright_done: got timeout want pulse"); end
    checks++; if (map[8][8] !== 8'd180) begin errors++; $display("FAIL bright_score: got %0d want 180", map[8][8]); end
    checks++; if (map10[8][8] !== 8'd0) begin errors++; $display("FAIL bright_arc10: got %0d want 0", map10[8][8]); end
    checks++; if (map[3][3] !== 8'd0) begin errors++; $display("FAIL bright_far: got %0d want 0", map[3][3]); end
  endtask

  task automatic test_dark_wrap;
    int d0, w0;
    bit to;
    paint_fill(8'd60);
    for (int k = 12; k <= 15; k++) paint_ring(3, 3, k, 8'd10);
    for (int k = 0; k <= 4; k++) paint_ring(3, 3, k, 8'd10);
    d0 = done_count; w0 = wr_count;
    start_frame(8'd6, 8'd6, 8'd20);
    wait_done(d0, 300, to);
    checks++; if (to) begin errors++; $display("FAIL dark_done: got timeout want pulse"); end
    checks++; if (wr_count - w0 !== 1) begin errors++; $display("FAIL dark_writes: got %0d want 1", wr_count - w0); end
    checks++; if (map[3][3] !== 8'd255) begin errors++; $display("FAIL dark_saturate: got %0d want 255", map[3][3]); end
    checks++; if (map10[3][3] !== 8'd0) begin errors++; $display("FAIL dark_arc10: got %0d want 0", map10[3][3]); end
  endtask

  task automatic test_class_limits;
    int d0;
    bit to;
    paint_fill(8'd255);
    mem[3][3] = 8'd250;
    d0 = done_count;
    start_frame(8'd6, 8'd6, 8'd10);
    wait_done(d0, 300, to);
    checks++; if (to || map[3][3] !== 8'd0) begin errors++; $display("FAIL bright_overflow: got %0d timeout %0d want 0", map[3][3], to); end
    paint_fill(8'd0);
    mem[3][3] = 8'd5;
    d0 = done_count;
    start_frame(8'd6, 8'd6, 8'd10);
    wait_done(d0, 300, to);
    checks++; if (to || map[3][3] !== 8'd0) begin errors++; $display("FAIL dark_underflow: got %0d timeout %0d want 0", map[3][3], to); end
  endtask

  task automatic test_small_image;
    int d0, w0, r0;
    bit to;
    d0 = done_count; w0 = wr_count; r0 = ren_count;
    start_frame(8'd5, 8'd15, 8'd10);
    wait_done(d0, 20, to);
    repeat (3) @(negedge clk);
    checks++; if (to) begin errors++; $display("FAIL small_done: got timeout want pulse"); end
    checks++; if (done_cyc !== nt_cyc + 1) begin errors++; $display("FAIL small_done_cycle: got %0d want %0d", done_cyc, nt_cyc + 1); end
    checks++; if (ren_count - r0 !== 0) begin errors++; $display("FAIL small_reads: got %0d want 0", ren_count - r0); end
    checks++; if (wr_count - w0 !== 0) begin errors++; $display("FAIL small_writes: got %0d want 0", wr_count - w0); end
  endtask

  task automatic test_busy_ignored;
    int d0, w0, t0;
    bit to;
    paint_fill(8'd100);
    d0 = done_count; w0 = wr_count;
    start_frame(8'd6, 8'd6, 8'd10);
    t0 = nt_cyc;
    repeat (2) @(negedge clk);
    mx = 8'd15; my = 8'd15;
    nt = 1'b1;
    @(negedge clk);
    nt = 1'b0;
    wait_done(d0, 300, to);
    repeat (200) @(negedge clk);
    checks++; if (done_count - d0 !== 1) begin errors++; $display("FAIL busy_done_count: got %0d want 1", done_count - d0); end
    checks++; if (wr_count - w0 !== 1) begin errors++; $display("FAIL busy_writes: got %0d want 1", wr_count - w0); end
    checks++; if (done_cyc !== t0 + FLAT_PERIOD + 1) begin errors++; $display("FAIL busy_done_cycle: got %0d want %0d", done_cyc, t0 + FLAT_PERIOD + 1); end
  endtask

  task automatic test_reset_mid_frame;
    int d0, w0, n;
    paint_fill(8'd100);
    start_frame(8'd15, 8'd15, 8'd10);
    n = 0;
    while (bus.wen_corner !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++; if (bus.wen_corner !== 1'b1) begin errors++; $display("FAIL midreset_wen_seen: got %b want 1", bus.wen_corner); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.wen_corner !== 1'b0 || bus.wdat_corner !== 8'd0 || bus.x_addr_corner !== 9'd0) begin
      errors++; $display("FAIL midreset_outputs: wen %b wdat %0d x %0d want 0 0 0", bus.wen_corner, bus.wdat_corner, bus.x_addr_corner);
    end
    d0 = done_count; w0 = wr_count;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5200) @(negedge clk);
    checks++; if (done_count - d0 !== 0) begin errors++; $display("FAIL midreset_done: got %0d pulses want 0", done_count - d0); end
    checks++; if (wr_count - w0 !== 0) begin errors++; $display("FAIL midreset_writes: got %0d want 0", wr_count - w0); end
  endtask

  initial begin
    test_reset();
    test_flat();
    test_bright_corner();
    test_dark_wrap();
    test_class_limits();
    test_small_image();
    test_busy_ignored();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
